// File: rtl/jump_sched.sv
// Jump-unit scheduler: round-robin intake from two requesters into an
// issue FIFO, drained one op at a time by an IDLE/ISSUE/WAIT FSM.
module jump_sched #(
   parameter int DEPTH = 4,
   parameter int TAGW  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [132+TAGW:0] req0_data,
   input  logic [132+TAGW:0] req1_data,
   input  logic              flush,
   output logic              fu_EN,
   output logic              fu_JALR,
   output logic [3:0]        fu_cmp_ctrl,
   output logic [31:0]       fu_rs1,
   output logic [31:0]       fu_rs2,
   output logic [31:0]       fu_imm,
   output logic [31:0]       fu_PC,
   input  logic              fu_finish,
   input  logic [31:0]       fu_PC_jump,
   input  logic [31:0]       fu_PC_wb,
   input  logic              fu_is_jump,
   output logic              res_valid,
   output logic [TAGW-1:0]   res_tag,
   output logic [31:0]       res_PC_jump,
   output logic [31:0]       res_PC_wb,
   output logic              res_is_jump
);

   localparam int DW = 133 + TAGW;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t          state;
   logic [DW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            rr;
   logic            space;
   logic            enq;
   logic            deq;
   logic [DW-1:0]   enq_data;
   logic [DW-1:0]   head;
   logic [TAGW-1:0] fu_tag;
   logic [TAGW-1:0] tag_q;
   logic [31:0]     pc_jump_q;
   logic [31:0]     pc_wb_q;
   logic            is_jump_q;

   // rr = 1 means requester 1 wins when both are valid
   always_comb begin
      space      = ~rst & ~flush & (count < FULL);
      req0_ready = space & req0_valid & (~req1_valid | ~rr);
      req1_ready = space & req1_valid & (~req0_valid | rr);
      enq        = req0_ready | req1_ready;
      enq_data   = req1_ready ? req1_data : req0_data;
      deq        = (state == ISSUE) & ~flush;
      head       = mem[rd_ptr];
   end

   assign fu_EN     = (state == ISSUE) & ~flush;
   assign res_valid = fu_finish & (state == WAIT) & ~flush;

   assign res_tag     = res_valid ? fu_tag     : tag_q;
   assign res_PC_jump = res_valid ? fu_PC_jump : pc_jump_q;
   assign res_PC_wb   = res_valid ? fu_PC_wb   : pc_wb_q;
   assign res_is_jump = res_valid ? fu_is_jump : is_jump_q;

   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= enq_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rr          <= 1'b0;
         fu_tag      <= '0;
         fu_JALR     <= 1'b0;
         fu_cmp_ctrl <= '0;
         fu_rs1      <= '0;
         fu_rs2      <= '0;
         fu_imm      <= '0;
         fu_PC       <= '0;
         tag_q       <= '0;
         pc_jump_q   <= '0;
         pc_wb_q     <= '0;
         is_jump_q   <= 1'b0;
      end else begin
         if (req0_valid & req1_valid & enq) rr <= ~rr;
         if (res_valid) begin
            tag_q     <= fu_tag;
            pc_jump_q <= fu_PC_jump;
            pc_wb_q   <= fu_PC_wb;
            is_jump_q <= fu_is_jump;
         end
         if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
         end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            count <= count + (AW+1)'(enq) - (AW+1)'(deq);
            case (state)
               IDLE: begin
                  // operands latched here so they are stable from ISSUE on
                  if (count != '0) begin
                     {fu_tag, fu_JALR, fu_cmp_ctrl, fu_rs1,
                      fu_rs2, fu_imm, fu_PC} <= head;
                     state <= ISSUE;
                  end
               end
               ISSUE: begin
                  rd_ptr <= rd_ptr + AW'(1);
                  state  <= WAIT;
               end
               WAIT: begin
                  if (fu_finish) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jump_sched.sv
// Scoreboard bench for jump_sched with a behavioural jump-unit stub
// that answers one cycle after fu_EN unless stalled.
module tb_jump_sched;

   localparam int TAGW = 4;
   localparam int DW   = 133 + TAGW;

   typedef struct packed {
      logic [31:0] pcj;
      logic [31:0] pcw;
      logic        isj;
   } jres_t;

   typedef struct {
      logic [TAGW-1:0] tag;
      jres_t           r;
      int              cyc;
      bit              lat;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req0_valid = 1'b0;
   logic            req1_valid = 1'b0;
   logic            req0_ready;
   logic            req1_ready;
   logic [DW-1:0]   req0_data = '0;
   logic [DW-1:0]   req1_data = '0;
   logic            flush = 1'b0;
   logic            fu_EN;
   logic            fu_JALR;
   logic [3:0]      fu_cmp_ctrl;
   logic [31:0]     fu_rs1;
   logic [31:0]     fu_rs2;
   logic [31:0]     fu_imm;
   logic [31:0]     fu_PC;
   logic            fu_finish;
   logic [31:0]     fu_PC_jump;
   logic [31:0]     fu_PC_wb;
   logic            fu_is_jump;
   logic            res_valid;
   logic [TAGW-1:0] res_tag;
   logic [31:0]     res_PC_jump;
   logic [31:0]     res_PC_wb;
   logic            res_is_jump;

   int   n_vec = 0;
   int   n_bad = 0;
   int   ncyc  = 0;
   bit   acc0  = 0;
   bit   acc1  = 0;
   bit   exp_rr = 0;
   bit   lat_mode = 0;
   logic [TAGW-1:0] next_tag = '0;
   logic [68:0] last = '0;
   exp_t sb[$];

   logic  pend;
   logic  stall = 1'b0;
   jres_t jr;

   jump_sched #(.DEPTH(4), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_data(req0_data), .req1_data(req1_data),
      .flush(flush), .fu_EN(fu_EN), .fu_JALR(fu_JALR),
      .fu_cmp_ctrl(fu_cmp_ctrl), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
      .fu_imm(fu_imm), .fu_PC(fu_PC), .fu_finish(fu_finish),
      .fu_PC_jump(fu_PC_jump), .fu_PC_wb(fu_PC_wb),
      .fu_is_jump(fu_is_jump), .res_valid(res_valid),
      .res_tag(res_tag), .res_PC_jump(res_PC_jump),
      .res_PC_wb(res_PC_wb), .res_is_jump(res_is_jump)
   );

   always #5 clk = ~clk;

   // reference jump unit: 0001 JAL, 0010 BEQ, 0011 BNE, 0100 BLT
   function automatic jres_t jmp(logic jalr, logic [3:0] cmp,
                                 logic [31:0] rs1, logic [31:0] rs2,
                                 logic [31:0] imm, logic [31:0] pc);
      jres_t r;
      r.pcw = pc + 32'd4;
      r.pcj = jalr ? rs1 + imm : pc + imm;
      case (cmp)
         4'b0001: r.isj = 1'b1;
         4'b0010: r.isj = (rs1 == rs2);
         4'b0011: r.isj = (rs1 != rs2);
         4'b0100: r.isj = ($signed(rs1) < $signed(rs2));
         default: r.isj = 1'b0;
      endcase
      if (jalr) r.isj = 1'b1;
      return r;
   endfunction

   function automatic exp_t expect_of(logic [DW-1:0] d);
      exp_t e;
      e.tag = d[133 +: TAGW];
      e.r   = jmp(d[132], d[131:128], d[127:96], d[95:64],
                  d[63:32], d[31:0]);
      e.cyc = ncyc;
      e.lat = lat_mode;
      return e;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= 1'b0;
         jr   <= '0;
      end else if (fu_EN) begin
         pend <= 1'b1;
         jr   <= jmp(fu_JALR, fu_cmp_ctrl, fu_rs1, fu_rs2,
                     fu_imm, fu_PC);
      end else if (fu_finish) begin
         pend <= 1'b0;
      end
   end

   assign fu_finish  = pend & ~stall;
   assign fu_PC_jump = jr.pcj;
   assign fu_PC_wb   = jr.pcw;
   assign fu_is_jump = jr.isj;

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      acc0 = 0;
      acc1 = 0;
      if (rst) begin
         sb.delete();
         exp_rr = 0;
         last   = '0;
      end else if (flush) begin
         sb.delete();
      end else begin
         chk("one_grant", {req0_ready, req1_ready} == 2'b11, 0);
         if (req0_valid & req1_valid & (req0_ready | req1_ready)) begin
            chk("rr", req1_ready, exp_rr);
            exp_rr = ~exp_rr;
         end
         if (res_valid) begin
            if (sb.size() == 0) begin
               chk("res_unexp", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("res_tag", res_tag, e.tag);
               chk("res_pcj", res_PC_jump, e.r.pcj);
               chk("res_pcw", res_PC_wb, e.r.pcw);
               chk("res_isj", res_is_jump, e.r.isj);
               if (e.lat) chk("latency", ncyc - e.cyc, 3);
               last = {e.tag, e.r.pcj, e.r.pcw, e.r.isj};
            end
         end else begin
            chk("res_hold", {res_tag, res_PC_jump, res_PC_wb,
                             res_is_jump}, last);
         end
         acc0 = req0_valid & req0_ready;
         acc1 = req1_valid & req1_ready;
         if (acc0) sb.push_back(expect_of(req0_data));
         if (acc1) sb.push_back(expect_of(req1_data));
      end
   end

   function automatic logic [DW-1:0] mk(logic [TAGW-1:0] tag, logic jalr,
                                        logic [3:0] cmp, logic [31:0] rs1,
                                        logic [31:0] rs2, logic [31:0] imm,
                                        logic [31:0] pc);
      return {tag, jalr, cmp, rs1, rs2, imm, pc};
   endfunction

   function automatic logic [DW-1:0] rnd_op();
      logic [3:0] cmps [4] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100};
      logic [DW-1:0] d;
      d = mk(next_tag, $urandom_range(0, 3) == 0,
             cmps[$urandom_range(0, 3)],
             32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
             $urandom & 32'h0000_0FFC, $urandom & 32'h0000_FFFC);
      next_tag = next_tag + 1'b1;
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (acc0) req0_data = rnd_op();
      if (acc1) req1_data = rnd_op();
   endtask

   task automatic drain(int max);
      int n = 0;
      while ((sb.size() != 0 || pend) && n < max) begin
         step();
         n++;
      end
      chk("drain_timeout", sb.size() != 0, 0);
      step();
   endtask

   task automatic wait_en(int max);
      int n = 0;
      while (!fu_EN && n < max) begin
         step();
         n++;
      end
      chk("en_timeout", fu_EN, 1);
   endtask

   task automatic send0(logic [DW-1:0] d);
      req0_data  = d;
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
   endtask

   task automatic send1(logic [DW-1:0] d);
      req1_data  = d;
      req1_valid = 1'b1;
      step();
      req1_valid = 1'b0;
   endtask

   initial begin
      int en_cnt;
      // reset state, with a request already pending
      #1 rst = 1'b1;
      req0_data  = mk(4'd3, 1'b0, 4'b0010, 32'd5, 32'd5,
                      32'h10, 32'h100);
      req0_valid = 1'b1;
      #2;
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_en", fu_EN, 0);
      chk("rst_res", res_valid, 0);
      chk("rst_fu", {fu_JALR, fu_cmp_ctrl, fu_rs1, fu_rs2,
                     fu_imm, fu_PC}, 0);
      chk("rst_out", {res_tag, res_PC_jump, res_PC_wb,
                      res_is_jump}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      lat_mode = 1;

      // single BEQ op accepted at the first edge after reset
      #1 chk("first_rdy", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      drain(20);
      chk("beq_pcj", res_PC_jump, 32'h110);
      chk("beq_pcw", res_PC_wb, 32'h104);
      chk("beq_tag", {res_tag, res_is_jump}, {4'd3, 1'b1});

      // JALR op from requester 1
      send1(mk(4'd5, 1'b1, 4'b0001, 32'h2000, 32'd0,
               32'hFFFF_FFFC, 32'h300));
      drain(20);
      chk("jalr_pcj", res_PC_jump, 32'h1FFC);
      chk("jalr_isj", res_is_jump, 1);
      lat_mode = 0;

      // contention: both requesters valid every cycle
      rst = 1'b1;
      step();
      rst = 1'b0;
      req0_data  = rnd_op();
      req1_data  = rnd_op();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (40) step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain(80);

      // full boundary while the jump unit stalls in WAIT
      stall      = 1'b1;
      req0_data  = rnd_op();
      req1_data  = rnd_op();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (12) step();
      chk("full_cnt", dut.count, 4);
      chk("full_rdy", {req0_ready, req1_ready}, 0);
      stall = 1'b0;
      wait_en(20);
      chk("issue_rdy", {req0_ready, req1_ready}, 0);
      step();
      chk("reopen_rdy", req0_ready | req1_ready, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain(80);

      // flush coinciding with fu_finish in WAIT
      send0(rnd_op());
      wait_en(20);
      step();
      req0_data  = rnd_op();
      req0_valid = 1'b1;
      flush      = 1'b1;
      #1;
      chk("flush_fin", fu_finish, 1);
      chk("flush_res", res_valid, 0);
      chk("flush_rdy", req0_ready, 0);
      step();
      flush      = 1'b0;
      req0_valid = 1'b0;
      chk("flush_cnt", dut.count, 0);
      en_cnt = 0;
      repeat (6) begin
         step();
         en_cnt += int'(fu_EN);
      end
      chk("flush_noen", en_cnt, 0);

      // asynchronous reset in the middle of ISSUE
      send0(rnd_op());
      wait_en(20);
      rst = 1'b1;
      #1;
      chk("arst_en", fu_EN, 0);
      chk("arst_res", res_valid, 0);
      chk("arst_out", {res_tag, res_PC_jump}, 0);
      step();
      step();
      rst = 1'b0;
      repeat (6) step();
      chk("arst_cnt", dut.count, 0);
      send0(rnd_op());
      drain(20);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
